// File: rtl/debug_mem_arbiter.sv
// Arbitrates one fixed-latency memory port between the CPU core and the JTAG debug controller.
// Latched debug pulses take priority and stall the core. A tag pipeline routes read data back to the requester.
module debug_mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  cpu_clk,
  input  logic                  sys_rstn,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  input  logic                  dbg_ce,
  input  logic                  dbg_we,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_rdata_ready,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  input  logic                  core_ce,
  input  logic                  core_we,
  output logic                  core_stall,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_rvalid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ce,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef struct packed {
    logic core_rd;
    logic dbg_rd;
  } tag_t;

  logic                  pend_r;
  logic                  pend_we_r;
  logic [ADDR_WIDTH-1:0] pend_addr_r;
  logic [DATA_WIDTH-1:0] pend_wdata_r;
  tag_t                  tag_r [MEM_LATENCY];
  tag_t                  issue_tag_s;
  tag_t                  tail_tag_s;
  logic [DATA_WIDTH-1:0] dbg_rdata_r;
  logic                  dbg_rdata_ready_r;

  // Debug request latch: a new pulse always overwrites, otherwise the pending access issues once.
  always_ff @(posedge cpu_clk) begin
    if (!sys_rstn) begin
      pend_r       <= 1'b0;
      pend_we_r    <= 1'b0;
      pend_addr_r  <= '0;
      pend_wdata_r <= '0;
    end else if (dbg_ce) begin
      pend_r       <= 1'b1;
      pend_we_r    <= dbg_we;
      pend_addr_r  <= dbg_addr;
      pend_wdata_r <= dbg_wdata;
    end else begin
      pend_r       <= 1'b0;
    end
  end

  // Memory port mux and tag of the access issued this cycle.
  always_comb begin
    mem_ce      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = core_addr;
    mem_wdata   = core_wdata;
    core_stall  = 1'b0;
    issue_tag_s = '0;
    if (!sys_rstn) begin
      mem_ce      = 1'b0;
      mem_we      = 1'b0;
      core_stall  = 1'b0;
    end else if (pend_r) begin
      mem_ce             = 1'b1;
      mem_we             = pend_we_r;
      mem_addr           = pend_addr_r;
      mem_wdata          = pend_wdata_r;
      core_stall         = 1'b1;
      issue_tag_s.dbg_rd = ~pend_we_r;
    end else begin
      mem_ce              = core_ce;
      mem_we              = core_we;
      issue_tag_s.core_rd = core_ce & ~core_we;
    end
  end

  // Tag pipeline aligned with the memory read latency.
  always_ff @(posedge cpu_clk) begin
    if (!sys_rstn) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        tag_r[i] <= '0;
      end
    end else begin
      tag_r[0] <= issue_tag_s;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  assign tail_tag_s  = tag_r[MEM_LATENCY-1];
  assign core_rdata  = mem_rdata;
  assign core_rvalid = sys_rstn & tail_tag_s.core_rd;

  // Debug read-back register; the ready pulse lines up with the captured data.
  always_ff @(posedge cpu_clk) begin
    if (!sys_rstn) begin
      dbg_rdata_r       <= '0;
      dbg_rdata_ready_r <= 1'b0;
    end else if (tail_tag_s.dbg_rd) begin
      dbg_rdata_r       <= mem_rdata;
      dbg_rdata_ready_r <= 1'b1;
    end else begin
      dbg_rdata_ready_r <= 1'b0;
    end
  end

  assign dbg_rdata       = dbg_rdata_r;
  assign dbg_rdata_ready = dbg_rdata_ready_r;

endmodule
